// File: rtl/pack_queue.sv
// pack_queue: gathers RATIO narrow input beats into one wide word, with an
// early flush on last_in (lane-keep mask) and a registered output stage that
// lets the accumulator keep filling while the downstream consumer stalls.
module pack_queue #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 32,
    localparam int RATIO    = OUT_WIDTH / IN_WIDTH,
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ap_start,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 vld_in,
    input  logic                 last_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic [RATIO-1:0]     keep_out,
    output logic                 last_out,
    output logic                 vld_out,
    input  logic                 rdy_downward,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    logic                 ap_start_q;
    logic                 start_edge;
    logic [OUT_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]     acc_keep;
    logic [IDX_W-1:0]     idx;
    logic [OUT_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]     merged_keep;
    logic                 last_lane;
    logic                 acc;
    logic                 emit;
    logic                 complete;

    assign start_edge = ap_start && !ap_start_q;
    assign last_lane  = (idx == IDX_W'(RATIO - 1));

    // Non-completing beats always fit in the accumulator; a completing beat
    // needs the output register free or draining. Nothing enters on restart.
    assign rdy_upward = !start_edge &&
                        (!vld_out || rdy_downward || (!last_lane && !last_in));
    assign acc        = vld_in && rdy_upward;
    assign emit       = vld_out && rdy_downward;
    assign complete   = acc && (last_lane || last_in);

    // Accumulator with the incoming beat merged into lane idx; lanes not yet
    // written are still zero because the accumulator clears per word.
    genvar k;
    generate
        for (k = 0; k < RATIO; k++) begin : g_lane
            assign merged_data[k*IN_WIDTH +: IN_WIDTH] =
                (idx == IDX_W'(k)) ? din : acc_data[k*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate
    assign merged_keep = acc_keep | (RATIO'(1) << idx);

    // Registered copy of ap_start for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ap_start_q <= 1'b0;
        else        ap_start_q <= ap_start;
    end

    // Accumulator: write lane on each accepted beat, clear on word completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (start_edge || complete) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (acc) begin
            acc_data <= merged_data;
            acc_keep <= merged_keep;
            idx      <= idx + IDX_W'(1);
        end
    end

    // Output register: a completion overwrites it (back-to-back with an emit),
    // otherwise an emit empties it; contents hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout     <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
            vld_out  <= 1'b0;
        end else if (start_edge) begin
            dout     <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
            vld_out  <= 1'b0;
        end else if (complete) begin
            dout     <= merged_data;
            keep_out <= merged_keep;
            last_out <= last_in;
            vld_out  <= 1'b1;
        end else if (emit) begin
            vld_out  <= 1'b0;
        end
    end

    // Count of words handed downstream since reset or restart; wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          word_cnt <= '0;
        else if (start_edge) word_cnt <= '0;
        else if (emit)       word_cnt <= word_cnt + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_pack_queue.sv
// Directed bench for pack_queue: default 32->64 instance plus a 16->64
// instance for the partial-flush case.
module tb_pack_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic [31:0] din;
    logic        vld_in, last_in, rdy_downward;
    logic        rdy_upward, last_out, vld_out;
    logic [63:0] dout;
    logic [1:0]  keep_out;
    logic [31:0] word_cnt;

    logic        ap_start2;
    logic [15:0] din2;
    logic        vld_in2, last_in2, rdy_downward2;
    logic        rdy_upward2, last_out2, vld_out2;
    logic [63:0] dout2;
    logic [3:0]  keep_out2;
    logic [31:0] word_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pack_queue dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .din(din),
        .vld_in(vld_in), .last_in(last_in), .rdy_upward(rdy_upward),
        .dout(dout), .keep_out(keep_out), .last_out(last_out),
        .vld_out(vld_out), .rdy_downward(rdy_downward), .word_cnt(word_cnt)
    );

    pack_queue #(.IN_WIDTH(16), .OUT_WIDTH(64), .CNT_WIDTH(32)) dut16 (
        .clk(clk), .reset(reset), .ap_start(ap_start2), .din(din2),
        .vld_in(vld_in2), .last_in(last_in2), .rdy_upward(rdy_upward2),
        .dout(dout2), .keep_out(keep_out2), .last_out(last_out2),
        .vld_out(vld_out2), .rdy_downward(rdy_downward2), .word_cnt(word_cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        din = d; vld_in = 1'b1; last_in = l;
    endtask

    task automatic idle();
        din = '0; vld_in = 1'b0; last_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ap_start = 1'b0; rdy_downward = 1'b1;
        idle();
        ap_start2 = 1'b0; din2 = '0; vld_in2 = 1'b0; last_in2 = 1'b0; rdy_downward2 = 1'b1;
        #1;
        // reset state
        chk("rst_vld",  64'(vld_out), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_keep", 64'(keep_out), 64'd0);
        chk("rst_cnt",  64'(word_cnt), 64'd0);
        chk("rst_rdy",  64'(rdy_upward), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // back-to-back full words
        beat(32'h11, 1'b0); tick();
        beat(32'h22, 1'b0); tick();
        chk("w1_vld",  64'(vld_out), 64'd1);
        chk("w1_dout", dout, 64'h0000002200000011);
        chk("w1_keep", 64'(keep_out), 64'd3);
        chk("w1_last", 64'(last_out), 64'd0);
        beat(32'h33, 1'b0); tick();
        chk("w1_drain_vld", 64'(vld_out), 64'd0);
        beat(32'h44, 1'b0); tick();
        chk("w2_dout", dout, 64'h0000004400000033);
        chk("w2_keep", 64'(keep_out), 64'd3);
        idle(); tick();
        chk("w2_cnt", 64'(word_cnt), 64'd2);
        chk("w2_vld", 64'(vld_out), 64'd0);

        // downstream stall
        beat(32'hA1, 1'b0); tick();
        beat(32'hA2, 1'b0); rdy_downward = 1'b0; tick();
        chk("st_vld", 64'(vld_out), 64'd1);
        beat(32'hB1, 1'b0); #1;
        chk("st_rdy_noncompl", 64'(rdy_upward), 64'd1);
        tick();
        beat(32'hB2, 1'b0); #1;
        chk("st_rdy_compl", 64'(rdy_upward), 64'd0);
        tick();
        chk("st_hold_dout", dout, 64'h000000A2000000A1);
        chk("st_hold_vld", 64'(vld_out), 64'd1);
        rdy_downward = 1'b1; #1;
        chk("st_rdy_release", 64'(rdy_upward), 64'd1);
        tick();
        chk("st_b2b_vld", 64'(vld_out), 64'd1);
        chk("st_b2b_dout", dout, 64'h000000B2000000B1);
        chk("st_b2b_cnt", 64'(word_cnt), 64'd3);
        idle(); tick();
        chk("st_cnt", 64'(word_cnt), 64'd4);
        chk("st_end_vld", 64'(vld_out), 64'd0);

        // single-beat flush at idx 0
        beat(32'h5, 1'b1); tick();
        chk("one_dout", dout, 64'h5);
        chk("one_keep", 64'(keep_out), 64'd1);
        chk("one_last", 64'(last_out), 64'd1);
        idle(); tick();
        chk("one_cnt", 64'(word_cnt), 64'd5);

        // restart discards the stale partial word and the edge-cycle beat
        beat(32'h99, 1'b0); tick();
        beat(32'hDEAD, 1'b0); ap_start = 1'b1; #1;
        chk("rs_rdy", 64'(rdy_upward), 64'd0);
        tick();
        chk("rs_cnt0", 64'(word_cnt), 64'd0);
        chk("rs_vld0", 64'(vld_out), 64'd0);
        beat(32'h7, 1'b0); tick();
        beat(32'h8, 1'b0); tick();
        chk("rs_dout", dout, 64'h0000000800000007);
        chk("rs_keep", 64'(keep_out), 64'd3);
        idle(); ap_start = 1'b0; tick();
        chk("rs_cnt", 64'(word_cnt), 64'd1);

        // 16->64 partial flush
        din2 = 16'hAAAA; vld_in2 = 1'b1; tick();
        din2 = 16'hBBBB; tick();
        din2 = 16'hCCCC; last_in2 = 1'b1; tick();
        chk("p16_dout", dout2, 64'h0000CCCCBBBBAAAA);
        chk("p16_keep", 64'(keep_out2), 64'b0111);
        chk("p16_last", 64'(last_out2), 64'd1);
        vld_in2 = 1'b0; last_in2 = 1'b0; tick();
        chk("p16_cnt", 64'(word_cnt2), 64'd1);

        // asynchronous reset while a word is stalled
        beat(32'h1, 1'b1); rdy_downward = 1'b0; tick();
        idle();
        chk("ar_pre_vld", 64'(vld_out), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_vld",  64'(vld_out), 64'd0);
        chk("ar_dout", dout, 64'd0);
        chk("ar_keep", 64'(keep_out), 64'd0);
        chk("ar_last", 64'(last_out), 64'd0);
        chk("ar_cnt",  64'(word_cnt), 64'd0);
        chk("ar_rdy",  64'(rdy_upward), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
